// File: rtl/mod_updown_counter.sv
// -----------------------------------------------------------------------------
// mod_updown_counter
//
// Parametrised modulo up/down counter with parallel load, a terminal-count
// pulse and a sticky wrap flag. One clock domain.
//
// Optional feature macro: COUNTER_PRESCALE_EN
//   Defined   : an internal prescaler makes every PRESCALE-th enabled cycle
//               a step.
//   Undefined : every enabled cycle is a step and PRESCALE is ignored.
//
// Parameters
//   WIDTH    : counter width in bits (2..32)
//   MODULO   : count range 0..MODULO-1 (2 <= MODULO <= 2**WIDTH)
//   PRESCALE : enabled cycles per step when the prescaler is compiled in (>= 1)
//
// Ports
//   clk      : clock, all state updates on posedge
//   reset    : asynchronous active-low reset
//   clr      : synchronous clear of count, tc, wrap and prescaler
//   enable   : count enable
//   up       : direction, 1 = increment, 0 = decrement
//   load     : synchronous parallel load (clamped to MODULO-1)
//   load_val : load value
//   wrap_clr : synchronous clear of the sticky wrap flag
//   out      : current count (registered)
//   tc       : terminal-count pulse, one cycle per wrap (registered)
//   wrap     : sticky wrap flag (registered)
// -----------------------------------------------------------------------------
module mod_updown_counter #(
   parameter int     WIDTH    = 8,
   parameter longint MODULO   = 256,
   parameter int     PRESCALE = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             enable,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             wrap_clr,
   output logic [WIDTH-1:0] out,
   output logic             tc,
   output logic             wrap
);

   // Reject illegal parameter sets at elaboration time.
   if ((WIDTH < 2) || (WIDTH > 32)) begin : g_bad_width
      $error("mod_updown_counter: WIDTH out of range");
   end
   if ((MODULO < 64'sd2) || (MODULO > (64'sd1 <<< WIDTH))) begin : g_bad_modulo
      $error("mod_updown_counter: MODULO out of range");
   end
   if (PRESCALE < 1) begin : g_bad_prescale
      $error("mod_updown_counter: PRESCALE must be >= 1");
   end

   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 64'sd1);

   logic [WIDTH-1:0] out_q, out_d;
   logic             tc_q, tc_d;
   logic             wrap_q, wrap_d;
   logic             tick_s;
   logic             wrap_evt_s;
   logic [WIDTH-1:0] load_clamped_s;

`ifdef COUNTER_PRESCALE_EN
   localparam int            PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

   logic [PS_W-1:0] ps_q, ps_d;

   // Prescaler: counts enabled cycles, tick on the last phase.
   always_comb begin
      tick_s = (ps_q == PS_LAST);
      if (clr || load) begin
         ps_d = {PS_W{1'b0}};
      end else if (enable) begin
         if (tick_s) begin
            ps_d = {PS_W{1'b0}};
         end else begin
            ps_d = ps_q + PS_W'(1);
         end
      end else begin
         ps_d = ps_q;
      end
   end

   // Prescaler phase register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ps_q <= {PS_W{1'b0}};
      end else begin
         ps_q <= ps_d;
      end
   end
`else
   // Without the prescaler every enabled cycle is a step.
   always_comb begin
      tick_s = 1'b1;
   end
`endif

   // Out-of-range load values saturate at the top of the count range.
   always_comb begin
      if ({1'b0, load_val} > {1'b0, MAX_VAL}) begin
         load_clamped_s = MAX_VAL;
      end else begin
         load_clamped_s = load_val;
      end
   end

   // Next-state logic: clr > load > step > hold. Wrap compare precedes the
   // add/subtract so no intermediate leaves the 0..MODULO-1 range.
   always_comb begin
      out_d      = out_q;
      wrap_evt_s = 1'b0;
      if (clr) begin
         out_d = {WIDTH{1'b0}};
      end else if (load) begin
         out_d = load_clamped_s;
      end else if (enable && tick_s) begin
         if (up) begin
            if (out_q == MAX_VAL) begin
               out_d      = {WIDTH{1'b0}};
               wrap_evt_s = 1'b1;
            end else begin
               out_d = out_q + WIDTH'(1);
            end
         end else begin
            if (out_q == {WIDTH{1'b0}}) begin
               out_d      = MAX_VAL;
               wrap_evt_s = 1'b1;
            end else begin
               out_d = out_q - WIDTH'(1);
            end
         end
      end else begin
         out_d = out_q;
      end

      tc_d = wrap_evt_s;
      // A wrap event on the same edge as wrap_clr keeps the flag set.
      if (clr) begin
         wrap_d = 1'b0;
      end else begin
         wrap_d = (wrap_q & ~wrap_clr) | wrap_evt_s;
      end
   end

   // Output state registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_q  <= {WIDTH{1'b0}};
         tc_q   <= 1'b0;
         wrap_q <= 1'b0;
      end else begin
         out_q  <= out_d;
         tc_q   <= tc_d;
         wrap_q <= wrap_d;
      end
   end

   assign out  = out_q;
   assign tc   = tc_q;
   assign wrap = wrap_q;

endmodule

// File: tb/tb_mod_updown_counter.sv
module tb_mod_updown_counter;

   logic       clk;
   logic       reset;

   // DUT A: WIDTH=8, MODULO=256, PRESCALE=1
   logic       a_clr, a_enable, a_up, a_load, a_wrap_clr;
   logic [7:0] a_load_val;
   logic [7:0] a_out;
   logic       a_tc, a_wrap;

   // DUT B (PRESCALE=1) and DUT C (PRESCALE=4) share stimulus, MODULO=10
   logic       b_clr, b_enable, b_up, b_load, b_wrap_clr;
   logic [3:0] b_load_val;
   logic [3:0] b_out, c_out;
   logic       b_tc, b_wrap, c_tc, c_wrap;

   int checks;
   int errors;

   mod_updown_counter #(.WIDTH(8), .MODULO(256), .PRESCALE(1)) u_a (
      .clk(clk), .reset(reset), .clr(a_clr), .enable(a_enable), .up(a_up),
      .load(a_load), .load_val(a_load_val), .wrap_clr(a_wrap_clr),
      .out(a_out), .tc(a_tc), .wrap(a_wrap)
   );

   mod_updown_counter #(.WIDTH(4), .MODULO(10), .PRESCALE(1)) u_b (
      .clk(clk), .reset(reset), .clr(b_clr), .enable(b_enable), .up(b_up),
      .load(b_load), .load_val(b_load_val), .wrap_clr(b_wrap_clr),
      .out(b_out), .tc(b_tc), .wrap(b_wrap)
   );

   mod_updown_counter #(.WIDTH(4), .MODULO(10), .PRESCALE(4)) u_c (
      .clk(clk), .reset(reset), .clr(b_clr), .enable(b_enable), .up(b_up),
      .load(b_load), .load_val(b_load_val), .wrap_clr(b_wrap_clr),
      .out(c_out), .tc(c_tc), .wrap(c_wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock edge, then settle before inputs change or outputs are sampled.
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset = 1'b0;
      a_clr = 1'b0; a_enable = 1'b0; a_up = 1'b1; a_load = 1'b0;
      a_wrap_clr = 1'b0; a_load_val = 8'h00;
      b_clr = 1'b0; b_enable = 1'b0; b_up = 1'b1; b_load = 1'b0;
      b_wrap_clr = 1'b0; b_load_val = 4'h0;
      tick(2);
      chk("reset_out", {24'd0, a_out}, 32'd0);
      reset = 1'b1;
      tick(1);

      // ---------- A: async reset and basic up count ----------
      a_load = 1'b1; a_load_val = 8'h37;
      tick(1);
      a_load = 1'b0;
      chk("a_load37", {24'd0, a_out}, 32'h37);
      #2 reset = 1'b0;
      #1;
      chk("a_async_rst_out", {24'd0, a_out}, 32'd0);
      chk("a_async_rst_tc", {31'd0, a_tc}, 32'd0);
      chk("a_async_rst_wrap", {31'd0, a_wrap}, 32'd0);
      reset = 1'b1;
      a_enable = 1'b1; a_up = 1'b1;
      tick(5);
      chk("a_up5", {24'd0, a_out}, 32'd5);

      // A: full-range wrap at 255 both ways
      a_enable = 1'b0; a_load = 1'b1; a_load_val = 8'hFF;
      tick(1);
      a_load = 1'b0;
      chk("a_load255", {24'd0, a_out}, 32'd255);
      a_enable = 1'b1;
      tick(1);
      chk("a_wrap_up_out", {24'd0, a_out}, 32'd0);
      chk("a_wrap_up_tc", {31'd0, a_tc}, 32'd1);
      chk("a_wrap_up_flag", {31'd0, a_wrap}, 32'd1);
      tick(1);
      chk("a_up_after_wrap", {24'd0, a_out}, 32'd1);
      chk("a_tc_single", {31'd0, a_tc}, 32'd0);
      a_up = 1'b0;
      tick(2);
      chk("a_wrap_dn_out", {24'd0, a_out}, 32'd255);
      chk("a_wrap_dn_tc", {31'd0, a_tc}, 32'd1);
      a_enable = 1'b0;

      // ---------- B: up wrap at MODULO=10 ----------
      b_clr = 1'b1;
      tick(1);
      b_clr = 1'b0;
      b_load = 1'b1; b_load_val = 4'd8;
      tick(1);
      b_load = 1'b0;
      chk("b_load8", {28'd0, b_out}, 32'd8);
      b_enable = 1'b1; b_up = 1'b1;
      tick(1);
      chk("b_up9", {28'd0, b_out}, 32'd9);
      chk("b_up9_tc", {31'd0, b_tc}, 32'd0);
      tick(1);
      chk("b_wrap0", {28'd0, b_out}, 32'd0);
      chk("b_wrap0_tc", {31'd0, b_tc}, 32'd1);
      chk("b_wrap0_flag", {31'd0, b_wrap}, 32'd1);
      b_enable = 1'b0;
      tick(1);
      chk("b_tc_drop", {31'd0, b_tc}, 32'd0);
      chk("b_wrap_sticky", {31'd0, b_wrap}, 32'd1);
      b_wrap_clr = 1'b1;
      tick(1);
      b_wrap_clr = 1'b0;
      chk("b_wrap_clr", {31'd0, b_wrap}, 32'd0);

      // B: down wrap and direction change
      b_load = 1'b1; b_load_val = 4'd1;
      tick(1);
      b_load = 1'b0;
      b_enable = 1'b1; b_up = 1'b0;
      tick(1);
      chk("b_dn0", {28'd0, b_out}, 32'd0);
      chk("b_dn0_tc", {31'd0, b_tc}, 32'd0);
      tick(1);
      chk("b_dn_wrap9", {28'd0, b_out}, 32'd9);
      chk("b_dn_wrap_tc", {31'd0, b_tc}, 32'd1);
      b_up = 1'b1;
      tick(1);
      chk("b_dir_up0", {28'd0, b_out}, 32'd0);
      chk("b_dir_up_tc", {31'd0, b_tc}, 32'd1);
      b_enable = 1'b0;

      // B: clr beats load and enable
      b_clr = 1'b1; b_load = 1'b1; b_load_val = 4'd5; b_enable = 1'b1;
      tick(1);
      b_clr = 1'b0; b_load = 1'b0; b_enable = 1'b0;
      chk("b_clr_prio_out", {28'd0, b_out}, 32'd0);
      chk("b_clr_prio_wrap", {31'd0, b_wrap}, 32'd0);

      // B: load clamp
      b_load = 1'b1; b_load_val = 4'd12;
      tick(1);
      chk("b_clamp12", {28'd0, b_out}, 32'd9);
      b_load_val = 4'd10;
      tick(1);
      chk("b_clamp10", {28'd0, b_out}, 32'd9);
      b_load = 1'b0;

      // B: wrap event and wrap_clr on the same edge -> set wins
      b_enable = 1'b1; b_up = 1'b1; b_wrap_clr = 1'b1;
      tick(1);
      chk("b_set_wins_out", {28'd0, b_out}, 32'd0);
      chk("b_set_wins_flag", {31'd0, b_wrap}, 32'd1);
      b_enable = 1'b0;
      tick(1);
      b_wrap_clr = 1'b0;
      chk("b_clr_after_set", {31'd0, b_wrap}, 32'd0);

      // B: load beats enable, no tc
      b_load = 1'b1; b_load_val = 4'd9; b_enable = 1'b1;
      tick(1);
      b_load = 1'b0; b_enable = 1'b0;
      chk("b_load_prio_out", {28'd0, b_out}, 32'd9);
      chk("b_load_prio_tc", {31'd0, b_tc}, 32'd0);

      // ---------- C: prescaler behaviour ----------
      b_clr = 1'b1;
      tick(1);
      b_clr = 1'b0;
      b_enable = 1'b1; b_up = 1'b1;
`ifdef COUNTER_PRESCALE_EN
      tick(3);
      chk("c_ps_3", {28'd0, c_out}, 32'd0);
      chk("b_ps1_3", {28'd0, b_out}, 32'd3);
      tick(1);
      chk("c_ps_4", {28'd0, c_out}, 32'd1);
      tick(4);
      chk("c_ps_8", {28'd0, c_out}, 32'd2);
      // enable dropped for 3 cycles mid-phase
      tick(2);
      b_enable = 1'b0;
      tick(3);
      b_enable = 1'b1;
      tick(1);
      chk("c_pause_hold", {28'd0, c_out}, 32'd2);
      tick(1);
      chk("c_pause_step", {28'd0, c_out}, 32'd3);
      // load restarts the phase
      tick(2);
      b_load = 1'b1; b_load_val = 4'd0;
      tick(1);
      b_load = 1'b0;
      tick(3);
      chk("c_load_phase_hold", {28'd0, c_out}, 32'd0);
      tick(1);
      chk("c_load_phase_step", {28'd0, c_out}, 32'd1);
      // async reset mid-phase
      b_enable = 1'b0;
      b_load = 1'b1; b_load_val = 4'd7;
      tick(1);
      b_load = 1'b0; b_enable = 1'b1;
      tick(2);
      chk("c_pre_rst", {28'd0, c_out}, 32'd7);
      #2 reset = 1'b0;
      #1;
      chk("c_async_rst", {28'd0, c_out}, 32'd0);
      chk("c_async_rst_tc", {31'd0, c_tc}, 32'd0);
      chk("c_async_rst_wrap", {31'd0, c_wrap}, 32'd0);
      reset = 1'b1;
      tick(3);
      chk("c_post_rst_hold", {28'd0, c_out}, 32'd0);
      tick(1);
      chk("c_post_rst_step", {28'd0, c_out}, 32'd1);
`else
      tick(3);
      chk("c_nops_3", {28'd0, c_out}, 32'd3);
      b_enable = 1'b0;
      tick(3);
      chk("c_nops_hold", {28'd0, c_out}, 32'd3);
      b_load = 1'b1; b_load_val = 4'd7;
      tick(1);
      b_load = 1'b0;
      chk("c_pre_rst", {28'd0, c_out}, 32'd7);
      #2 reset = 1'b0;
      #1;
      chk("c_async_rst", {28'd0, c_out}, 32'd0);
      chk("c_async_rst_tc", {31'd0, c_tc}, 32'd0);
      chk("c_async_rst_wrap", {31'd0, c_wrap}, 32'd0);
      reset = 1'b1;
      b_enable = 1'b1;
      tick(1);
      chk("c_post_rst_step", {28'd0, c_out}, 32'd1);
`endif
      b_enable = 1'b0;
      tick(1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
